truth_table_scan: RTL

TRUTH_TABLE_SCAN -- requirements
Module: truth_table_scan

---
 rtl/truth_table_scan.sv | 120 ++++++++++++
 1 files changed

// File: rtl/truth_table_scan.sv
// Exhaustive 3-input truth-table scanner: steps {x1,x2,x3} through 000..111, holds each
// vector DWELL cycles, captures f into tt. Optional compare against expected: TRUTH_TABLE_SCAN_COMPARE_EN.
module truth_table_scan #(
  parameter int unsigned DWELL = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       f,
  input  logic [7:0] expected,
  output logic       x1,
  output logic       x2,
  output logic       x3,
  output logic       busy,
  output logic       done,
  output logic [7:0] tt,
  output logic       pass,
  output logic [3:0] mismatch_cnt,
  output logic [2:0] first_fail
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [7:0] LP_LAST = 8'(DWELL - 1);

  state_t     r_state;
  state_t     w_next;
  logic [2:0] r_idx;
  logic [7:0] r_cnt;
  logic [7:0] r_tt;
  logic       w_last;
  logic       w_go;

  assign w_last = (r_state == S_SCAN) && (r_cnt == LP_LAST);
  assign w_go   = start && (r_state != S_SCAN);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_SCAN;
      S_SCAN:  if (w_last && (r_idx == 3'd7)) w_next = S_DONE;
      S_DONE:  if (start) w_next = S_SCAN;
      default: w_next = S_IDLE;
    endcase
  end

  // idx stays at 7 on the final sample, so x reads 111 throughout DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx <= '0;
      r_cnt <= '0;
      r_tt  <= '0;
    end else if (w_go) begin
      r_idx <= '0;
      r_cnt <= '0;
      r_tt  <= '0;
    end else if (r_state == S_SCAN) begin
      if (w_last) begin
        r_tt[r_idx] <= f;
        r_cnt       <= '0;
        if (r_idx != 3'd7) begin
          r_idx <= r_idx + 3'd1;
        end
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  assign {x1, x2, x3} = r_idx;
  assign busy         = (r_state == S_SCAN);
  assign done         = (r_state == S_DONE);
  assign tt           = r_tt;

`ifdef TRUTH_TABLE_SCAN_COMPARE_EN
  logic [7:0] r_exp;
  logic [3:0] r_mcnt;
  logic [2:0] r_ff;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_exp  <= '0;
      r_mcnt <= '0;
      r_ff   <= '0;
    end else if (w_go) begin
      r_exp  <= expected;
      r_mcnt <= '0;
      r_ff   <= '0;
    end else if (w_last && (f != r_exp[r_idx])) begin
      if (r_mcnt == 4'd0) begin
        r_ff <= r_idx;
      end
      r_mcnt <= r_mcnt + 4'd1;
    end
  end

  assign pass         = (r_state == S_DONE) && (r_mcnt == 4'd0);
  assign mismatch_cnt = r_mcnt;
  assign first_fail   = r_ff;
`else
  logic w_unused;
  assign w_unused     = ^expected;
  assign pass         = 1'b0;
  assign mismatch_cnt = '0;
  assign first_fail   = '0;
`endif

endmodule
